conv_pool_seq_ctrl: RTL
=======================

// Module: conv_pool_seq_ctrl
// PURPOSE
//  Parametrised address/control sequencer for the mini CNN system: "same"-size KxK conv over
//  CH input channels with zero padding, then optional POOLxPOOL pooling of the conv map.
//  Drives the input ROM, weight ROM, conv RAM and pool RAM, plus the MAC/pool datapath
//  strobes. Replaces the fixed 256x256 / 3x3 / single-channel controller.
// PARAMETERS
//  ADDR_BITS  16   width of every memory address port
//  IMG_W      256  input/conv map width in pixels
//  IMG_H      256  input/conv map height in pixels
//  K          3    kernel size; odd, >=1; PAD=(K-1)/2
//  CH         1    input channels accumulated per output pixel
//  POOL       2    pooling window/stride; 0 = no pooling phase; IMG_W and IMG_H divisible by POOL
//  RD_LAT     1    datapath read-to-result latency in cycles, >=0
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          reset, asynchronous, active-high
//  start        in   1          begin a frame; sampled only in IDLE or DONE
//  busy         out  1          high from the first tap cycle until DONE is entered
//  done         out  1          frame complete; held high in DONE
//  rom_if_a     out  ADDR_BITS  input address = ch*IMG_H*IMG_W + y*IMG_W + x
//  rom_if_oe    out  1          input ROM read enable; 0 on padded taps
//  rom_w_a      out  ADDR_BITS  weight address = ch*K*K + ky*K + kx
//  rom_w_oe     out  1          weight ROM read enable, every tap cycle
//  pad_en       out  1          current tap lies outside the image; datapath substitutes 0
//  clear        out  1          accumulator clear, asserted with the first tap of each pixel
//  acc_en       out  1          MAC accumulate enable, every tap cycle
//  ram_conv_a   out  ADDR_BITS  conv RAM address: r*IMG_W+c (write) or pool read address
//  ram_conv_we  out  1          conv RAM write strobe
//  ram_conv_oe  out  1          conv RAM read enable during pool reads
//  ram_pool_a   out  ADDR_BITS  pool RAM address = pr*(IMG_W/POOL)+pc
//  ram_pool_we  out  1          pool RAM write strobe
//  pool_en      out  1          pool unit compare/accumulate enable
//  pool_first   out  1          first element of a pool window; pool unit reloads
// BEHAVIOUR
//  - All outputs are registered. On rst, every output is 0 and the FSM goes to IDLE, including
//    mid-frame. All counters are cleared.
//  - States: IDLE, C_TAP, C_DRN, C_WR, P_RD, P_DRN, P_WR, DONE.
//  - Cycle 1 is the first cycle after the edge that samples start.
//  - IDLE: on start, go to C_TAP with pixel (r,c)=(0,0) and tap (ch,ky,kx)=(0,0,0).
//  - C_TAP: one tap per cycle, K*K*CH cycles per pixel. kx is the fastest index, then ky, then ch.
//    Input coordinate is y=r+ky-PAD, x=c+kx-PAD.
//    If y or x is out of range: pad_en=1, rom_if_oe=0, rom_if_a=0. Otherwise pad_en=0, rom_if_oe=1.
//    clear=1 only on the tap (0,0,0). rom_w_oe=1 and acc_en=1 on every tap.
//  - C_DRN: RD_LAT cycles with all strobes 0 (skipped if RD_LAT=0).
//  - C_WR: one cycle, ram_conv_we=1, ram_conv_a=r*IMG_W+c.
//    Pixel order is raster, c fastest. Go to C_TAP for the next pixel.
//    After the last pixel, go to P_RD if POOL>0, else to DONE.
//  - P_RD: POOL*POOL cycles per window, in raster order within the window.
//    ram_conv_oe=1, pool_en=1, ram_conv_a=(pr*POOL+i)*IMG_W+pc*POOL+j. pool_first=1 on (i,j)=(0,0).
//  - P_DRN: RD_LAT idle cycles.
//  - P_WR: one cycle, ram_pool_we=1. Next window, or DONE after the last window.
//  - Cycles per conv pixel: K*K*CH+RD_LAT+1. Cycles per pool window: POOL*POOL+RD_LAT+1.
//  - DONE: done=1, busy=0, held. start restarts the frame at cycle 1 and clears done that cycle.
//  - start while busy is ignored. All address arithmetic is unsigned, truncated to ADDR_BITS.
//  - Strobes never overlap: ram_conv_we is never high in the same cycle as ram_conv_oe.
// TESTING
//  T1 IMG 4x4, K=3, CH=1, POOL=2, RD_LAT=1, start:
//     cyc1 tap(0,0,0): pad_en=1, rom_if_oe=0, clear=1. cyc5 (centre tap): rom_if_a=0, rom_w_a=4.
//     cyc11: ram_conv_we=1, ram_conv_a=0.
//  T2 Same config: total conv 16*11=176 cycles. Pool reads at cyc177-180 use conv addr 0,1,4,5.
//     cyc182: ram_pool_we=1, ram_pool_a=0. done=1 at cyc201.
//  T3 Pixel (3,3) of 4x4, K=3: exactly 5 of 9 taps have pad_en=1.
//     Corner pixel (0,0) has 5 padded taps. Interior pixel (1,1) has 0.
//  T4 CH=2, 4x4: rom_w_a runs 0..17 per pixel; pixel (1,1) tap (1,0,0) gives rom_if_a=16.
//     Conv write at per-pixel cycle 20.
//  T5 POOL=0: done=1 at cyc177, and no ram_conv_oe, pool_en or ram_pool_we is ever seen.
//  T6 Assert rst at cyc50: all outputs 0 immediately. A new start gives the T1 sequence exactly.
//     A start pulse while busy has no effect.

Source files
------------

// File: rtl/conv_pool_seq_ctrl.sv
// Address/control sequencer for same-size KxK multi-channel conv followed by optional POOLxPOOL pooling.
// All outputs are registered from the next-state values, so they line up with the state being entered.
module conv_pool_seq_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int K         = 3,
  parameter int CH        = 1,
  parameter int POOL      = 2,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] rom_if_a,
  output logic                 rom_if_oe,
  output logic [ADDR_BITS-1:0] rom_w_a,
  output logic                 rom_w_oe,
  output logic                 pad_en,
  output logic                 clear,
  output logic                 acc_en,
  output logic [ADDR_BITS-1:0] ram_conv_a,
  output logic                 ram_conv_we,
  output logic                 ram_conv_oe,
  output logic [ADDR_BITS-1:0] ram_pool_a,
  output logic                 ram_pool_we,
  output logic                 pool_en,
  output logic                 pool_first
);

  typedef enum logic [2:0] {IDLE, C_TAP, C_DRN, C_WR, P_RD, P_DRN, P_WR, DONE} state_t;

  // Guard the pool geometry so POOL=0 never divides by zero.
  localparam int PAD = (K - 1) / 2;
  localparam int PW  = (POOL > 0) ? IMG_W / POOL : 1;
  localparam int PH  = (POOL > 0) ? IMG_H / POOL : 1;
  localparam logic [31:0] KL  = 32'(K - 1);
  localparam logic [31:0] CL  = 32'(CH - 1);
  localparam logic [31:0] WL  = 32'(IMG_W - 1);
  localparam logic [31:0] HL  = 32'(IMG_H - 1);
  localparam logic [31:0] PL  = (POOL > 0) ? 32'(POOL - 1) : 32'd0;
  localparam logic [31:0] PWL = 32'(PW - 1);
  localparam logic [31:0] PHL = 32'(PH - 1);
  localparam logic [31:0] DL  = (RD_LAT > 0) ? 32'(RD_LAT - 1) : 32'd0;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] rom_if_a;
    logic                 rom_if_oe;
    logic [ADDR_BITS-1:0] rom_w_a;
    logic                 rom_w_oe;
    logic                 pad_en;
    logic                 clear;
    logic                 acc_en;
    logic [ADDR_BITS-1:0] ram_conv_a;
    logic                 ram_conv_we;
    logic                 ram_conv_oe;
    logic [ADDR_BITS-1:0] ram_pool_a;
    logic                 ram_pool_we;
    logic                 pool_en;
    logic                 pool_first;
  } out_t;

  state_t      state, ns;
  logic [31:0] r, c, ch, ky, kx, dc, pr, pc, pi, pj;
  logic [31:0] n_r, n_c, n_ch, n_ky, n_kx, n_dc, n_pr, n_pc, n_pi, n_pj;
  logic signed [31:0] yi, xi;
  out_t        o_nxt, o_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r <= '0; c <= '0; ch <= '0; ky <= '0; kx <= '0;
      dc <= '0; pr <= '0; pc <= '0; pi <= '0; pj <= '0;
    end else begin
      state <= ns;
      r <= n_r; c <= n_c; ch <= n_ch; ky <= n_ky; kx <= n_kx;
      dc <= n_dc; pr <= n_pr; pc <= n_pc; pi <= n_pi; pj <= n_pj;
    end
  end

  always_comb begin
    ns = state;
    n_r = r; n_c = c; n_ch = ch; n_ky = ky; n_kx = kx;
    n_dc = dc; n_pr = pr; n_pc = pc; n_pi = pi; n_pj = pj;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          ns = C_TAP;
          n_r = '0; n_c = '0; n_ch = '0; n_ky = '0; n_kx = '0;
          n_dc = '0; n_pr = '0; n_pc = '0; n_pi = '0; n_pj = '0;
        end
      end
      C_TAP: begin
        if (kx != KL) n_kx = kx + 1;
        else begin
          n_kx = '0;
          if (ky != KL) n_ky = ky + 1;
          else begin
            n_ky = '0;
            if (ch != CL) n_ch = ch + 1;
            else begin
              n_ch = '0;
              n_dc = '0;
              ns   = (RD_LAT > 0) ? C_DRN : C_WR;
            end
          end
        end
      end
      C_DRN: begin
        if (dc == DL) ns = C_WR;
        else n_dc = dc + 1;
      end
      C_WR: begin
        if (c != WL) begin
          n_c = c + 1;
          ns  = C_TAP;
        end else begin
          n_c = '0;
          if (r != HL) begin
            n_r = r + 1;
            ns  = C_TAP;
          end else begin
            n_r = '0;
            ns  = (POOL > 0) ? P_RD : DONE;
          end
        end
      end
      P_RD: begin
        if (pj != PL) n_pj = pj + 1;
        else begin
          n_pj = '0;
          if (pi != PL) n_pi = pi + 1;
          else begin
            n_pi = '0;
            n_dc = '0;
            ns   = (RD_LAT > 0) ? P_DRN : P_WR;
          end
        end
      end
      P_DRN: begin
        if (dc == DL) ns = P_WR;
        else n_dc = dc + 1;
      end
      P_WR: begin
        ns = P_RD;
        if (pc != PWL) n_pc = pc + 1;
        else begin
          n_pc = '0;
          if (pr != PHL) n_pr = pr + 1;
          else begin
            n_pr = '0;
            ns   = DONE;
          end
        end
      end
      default: ns = IDLE;
    endcase
  end

  // Signed input coordinates so padded taps on the top/left edge go negative.
  always_comb begin
    o_nxt = '0;
    yi    = $signed(n_r) + $signed(n_ky) - PAD;
    xi    = $signed(n_c) + $signed(n_kx) - PAD;
    unique case (ns)
      C_TAP: begin
        o_nxt.busy     = 1'b1;
        o_nxt.rom_w_oe = 1'b1;
        o_nxt.acc_en   = 1'b1;
        o_nxt.clear    = (n_ch == '0) && (n_ky == '0) && (n_kx == '0);
        o_nxt.rom_w_a  = ADDR_BITS'(n_ch * K * K + n_ky * K + n_kx);
        if (yi < 0 || yi >= IMG_H || xi < 0 || xi >= IMG_W) begin
          o_nxt.pad_en = 1'b1;
        end else begin
          o_nxt.rom_if_oe = 1'b1;
          o_nxt.rom_if_a  = ADDR_BITS'(n_ch * IMG_H * IMG_W + 32'(yi) * IMG_W + 32'(xi));
        end
      end
      C_DRN, P_DRN: o_nxt.busy = 1'b1;
      C_WR: begin
        o_nxt.busy        = 1'b1;
        o_nxt.ram_conv_we = 1'b1;
        o_nxt.ram_conv_a  = ADDR_BITS'(n_r * IMG_W + n_c);
      end
      P_RD: begin
        o_nxt.busy        = 1'b1;
        o_nxt.ram_conv_oe = 1'b1;
        o_nxt.pool_en     = 1'b1;
        o_nxt.pool_first  = (n_pi == '0) && (n_pj == '0);
        o_nxt.ram_conv_a  = ADDR_BITS'((n_pr * POOL + n_pi) * IMG_W + n_pc * POOL + n_pj);
      end
      P_WR: begin
        o_nxt.busy        = 1'b1;
        o_nxt.ram_pool_we = 1'b1;
        o_nxt.ram_pool_a  = ADDR_BITS'(n_pr * PW + n_pc);
      end
      DONE: o_nxt.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= '0;
    else     o_q <= o_nxt;
  end

  assign busy        = o_q.busy;
  assign done        = o_q.done;
  assign rom_if_a    = o_q.rom_if_a;
  assign rom_if_oe   = o_q.rom_if_oe;
  assign rom_w_a     = o_q.rom_w_a;
  assign rom_w_oe    = o_q.rom_w_oe;
  assign pad_en      = o_q.pad_en;
  assign clear       = o_q.clear;
  assign acc_en      = o_q.acc_en;
  assign ram_conv_a  = o_q.ram_conv_a;
  assign ram_conv_we = o_q.ram_conv_we;
  assign ram_conv_oe = o_q.ram_conv_oe;
  assign ram_pool_a  = o_q.ram_pool_a;
  assign ram_pool_we = o_q.ram_pool_we;
  assign pool_en     = o_q.pool_en;
  assign pool_first  = o_q.pool_first;

endmodule
